// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage request and pipeline-control response bundle for hazard_forward_ctrl.
// master = ID/fetch side, slave = the controller.
interface hazard_forward_ctrl_if #(
  parameter int unsigned AW = 5
);
  logic          id_valid;
  logic [AW-1:0] id_ra;
  logic [AW-1:0] id_rb;
  logic          id_use_a;
  logic          id_use_b;
  logic          id_imm_sel;
  logic [AW-1:0] id_rw;
  logic          id_wr_en;
  logic          id_is_load;
  logic          flush;

  logic          id_stall;
  logic [AW-1:0] bank_ra;
  logic [AW-1:0] bank_rb;
  logic [1:0]    mux_sel_A;
  logic [1:0]    mux_sel_B;
  logic          imm_sel;
  logic [AW-1:0] rw_dm;
  logic          op_valid;
  logic          ex_valid;
  logic          dm_valid;
  logic          wb_valid;

  modport master (
    output id_valid, id_ra, id_rb, id_use_a, id_use_b, id_imm_sel,
           id_rw, id_wr_en, id_is_load, flush,
    input  id_stall, bank_ra, bank_rb, mux_sel_A, mux_sel_B, imm_sel,
           rw_dm, op_valid, ex_valid, dm_valid, wb_valid
  );

  modport slave (
    input  id_valid, id_ra, id_rb, id_use_a, id_use_b, id_imm_sel,
           id_rw, id_wr_en, id_is_load, flush,
    output id_stall, bank_ra, bank_rb, mux_sel_A, mux_sel_B, imm_sel,
           rw_dm, op_valid, ex_valid, dm_valid, wb_valid
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Pipeline sequencer: tracks OP/EX/DM/WB destinations, selects operand forwarding
// and stalls ID on load-use (or any RAW hazard when forwarding is disabled).
module hazard_forward_ctrl #(
  parameter int unsigned AW     = 5,
  parameter bit          FWD_EN = 1'b1
) (
  input logic             clk,
  input logic             rst,
  hazard_forward_ctrl_if.slave bus
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic          use_a;
    logic          use_b;
    logic          imm_sel;
    logic [AW-1:0] rw;
    logic          wr_en;
    logic          is_load;
  } stage_t;

  stage_t op_q, op_d, ex_q, ex_d, dm_q, dm_d, wb_q, wb_d, id_s;

  logic ex_wr, dm_wr, wb_wr;
  logic live_a, live_b;
  logic ex_hit_a, dm_hit_a, wb_hit_a, ex_hit_b, dm_hit_b, wb_hit_b;
  logic ld_a, ld_b;
  logic stall;

  // Youngest producer wins; a load still in EX cannot forward yet.
  function automatic logic [1:0] prio(input logic live, input logic hex,
                                      input logic hdm, input logic hwb);
    if (!live) return 2'b00;
    if (hex)   return 2'b01;
    if (hdm)   return 2'b10;
    if (hwb)   return 2'b11;
    return 2'b00;
  endfunction

  always_comb begin
    ex_wr = ex_q.valid && ex_q.wr_en && (ex_q.rw != '0);
    dm_wr = dm_q.valid && dm_q.wr_en && (dm_q.rw != '0);
    wb_wr = wb_q.valid && wb_q.wr_en && (wb_q.rw != '0);

    live_a = op_q.valid && op_q.use_a && (op_q.ra != '0);
    live_b = op_q.valid && op_q.use_b && (op_q.rb != '0);

    ex_hit_a = ex_wr && (ex_q.rw == op_q.ra);
    dm_hit_a = dm_wr && (dm_q.rw == op_q.ra);
    wb_hit_a = wb_wr && (wb_q.rw == op_q.ra);
    ex_hit_b = ex_wr && (ex_q.rw == op_q.rb);
    dm_hit_b = dm_wr && (dm_q.rw == op_q.rb);
    wb_hit_b = wb_wr && (wb_q.rw == op_q.rb);

    ld_a = live_a && ex_hit_a && ex_q.is_load;
    ld_b = live_b && ex_hit_b && ex_q.is_load;

    stall = 1'b0;
    if (FWD_EN) begin
      stall = ld_a || ld_b;
    end else begin
      stall = (live_a && (ex_hit_a || dm_hit_a || wb_hit_a)) ||
              (live_b && (ex_hit_b || dm_hit_b || wb_hit_b));
    end
    if (bus.flush) stall = 1'b0;
  end

  always_comb begin
    id_s = '{valid: bus.id_valid, ra: bus.id_ra, rb: bus.id_rb,
             use_a: bus.id_use_a, use_b: bus.id_use_b, imm_sel: bus.id_imm_sel,
             rw: bus.id_rw, wr_en: bus.id_wr_en, is_load: bus.id_is_load};
    wb_d = dm_q;
    dm_d = ex_q;
    ex_d = op_q;
    op_d = id_s;
    if (bus.flush) begin
      ex_d = '0;
      op_d = '0;
    end else if (stall) begin
      ex_d = '0;
      op_d = op_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      ex_q <= '0;
      dm_q <= '0;
      wb_q <= '0;
    end else begin
      op_q <= op_d;
      ex_q <= ex_d;
      dm_q <= dm_d;
      wb_q <= wb_d;
    end
  end

  // During a stall the bank re-latches the held OP sources so its AR/BR stay current.
  assign bus.bank_ra   = stall ? op_q.ra : bus.id_ra;
  assign bus.bank_rb   = stall ? op_q.rb : bus.id_rb;
  assign bus.mux_sel_A = FWD_EN ? prio(live_a, ex_hit_a && !ex_q.is_load, dm_hit_a, wb_hit_a) : 2'b00;
  assign bus.mux_sel_B = FWD_EN ? prio(live_b, ex_hit_b && !ex_q.is_load, dm_hit_b, wb_hit_b) : 2'b00;
  assign bus.imm_sel   = op_q.imm_sel;
  assign bus.rw_dm     = dm_wr ? dm_q.rw : '0;
  assign bus.id_stall  = stall;
  assign bus.op_valid  = op_q.valid;
  assign bus.ex_valid  = ex_q.valid;
  assign bus.dm_valid  = dm_q.valid;
  assign bus.wb_valid  = wb_q.valid;

  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_q.ra, wb_q.rb, wb_q.use_a, wb_q.use_b,
                              wb_q.imm_sel, wb_q.is_load};

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares for a forwarding and a non-forwarding instance.
module tb_hazard_forward_ctrl;
  localparam int unsigned AW = 5;
  localparam int X = -1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_forward_ctrl_if #(.AW(AW)) bf ();
  hazard_forward_ctrl_if #(.AW(AW)) bn ();

  hazard_forward_ctrl #(.AW(AW), .FWD_EN(1'b1)) u_fwd (.clk(clk), .rst(rst), .bus(bf));
  hazard_forward_ctrl #(.AW(AW), .FWD_EN(1'b0)) u_nofwd (.clk(clk), .rst(rst), .bus(bn));

  typedef struct {
    string       name;
    logic [24:0] val;
    logic [24:0] mask;
  } exp_t;

  exp_t qf[$];
  exp_t qn[$];
  int   total = 0;
  int   bad   = 0;

  // {stall, bank_ra, bank_rb, selA, selB, imm_sel, rw_dm, op_v, ex_v, dm_v, wb_v}
  logic [24:0] act_f, act_n;
  assign act_f = {bf.id_stall, bf.bank_ra, bf.bank_rb, bf.mux_sel_A, bf.mux_sel_B,
                  bf.imm_sel, bf.rw_dm, bf.op_valid, bf.ex_valid, bf.dm_valid, bf.wb_valid};
  assign act_n = {bn.id_stall, bn.bank_ra, bn.bank_rb, bn.mux_sel_A, bn.mux_sel_B,
                  bn.imm_sel, bn.rw_dm, bn.op_valid, bn.ex_valid, bn.dm_valid, bn.wb_valid};

  // Negative field value = don't care.
  function automatic exp_t mk(string n, int st, int ra, int rb, int sa, int sb, int im,
                              int rwd, int opv, int exv, int dmv, int wbv);
    exp_t r;
    int   vals[11];
    int   w[11];
    vals = '{st, ra, rb, sa, sb, im, rwd, opv, exv, dmv, wbv};
    w    = '{1, 5, 5, 2, 2, 1, 5, 1, 1, 1, 1};
    r.name = n;
    r.val  = '0;
    r.mask = '0;
    for (int unsigned i = 0; i < 11; i++) begin
      logic [24:0] fm;
      fm = 25'((1 << w[i]) - 1);
      r.val  = r.val << w[i];
      r.mask = r.mask << w[i];
      if (vals[i] >= 0) begin
        r.val  = r.val | (25'(vals[i]) & fm);
        r.mask = r.mask | fm;
      end
    end
    return r;
  endfunction

  task automatic check(input string dut, input exp_t e, input logic [24:0] act);
    total++;
    if ((act & e.mask) != (e.val & e.mask)) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h (mask=%h)", dut, e.name,
               act & e.mask, e.val & e.mask, e.mask);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qf.size() != 0) begin
      e = qf.pop_front();
      check("fwd", e, act_f);
    end
    if (qn.size() != 0) begin
      e = qn.pop_front();
      check("nofwd", e, act_n);
    end
  end

  task automatic drv(input int nf, input int v, input int ra, input int rb, input int ua,
                     input int ub, input int im, input int rw, input int we, input int ld,
                     input int fl);
    if (nf != 0) begin
      bn.id_valid = 1'(v); bn.id_ra = AW'(ra); bn.id_rb = AW'(rb);
      bn.id_use_a = 1'(ua); bn.id_use_b = 1'(ub); bn.id_imm_sel = 1'(im);
      bn.id_rw = AW'(rw); bn.id_wr_en = 1'(we); bn.id_is_load = 1'(ld); bn.flush = 1'(fl);
    end else begin
      bf.id_valid = 1'(v); bf.id_ra = AW'(ra); bf.id_rb = AW'(rb);
      bf.id_use_a = 1'(ua); bf.id_use_b = 1'(ub); bf.id_imm_sel = 1'(im);
      bf.id_rw = AW'(rw); bf.id_wr_en = 1'(we); bf.id_is_load = 1'(ld); bf.flush = 1'(fl);
    end
  endtask

  task automatic bub(input int nf);
    drv(nf, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ex(input int nf, input exp_t e);
    if (nf != 0) qn.push_back(e);
    else         qf.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bub(0);
    bub(1);

    // Forwarding instance
    cyc(); drv(0, 1, 1, 2, 1, 1, 0, 3, 1, 0, 0);
    ex(0, mk("rst_hold",    0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(); rst = 1'b0;
    ex(0, mk("rst_release", 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(); drv(0, 1, 3, 3, 1, 1, 0, 4, 1, 0, 0);
    ex(0, mk("first_op",    0, 3, 3, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc(); drv(0, 1, 3, 0, 1, 0, 0, 7, 1, 0, 0);
    ex(0, mk("fwd_ex",      0, 3, 0, 1, 1, 0, 0, 1, 1, 0, 0));
    cyc(); drv(0, 1, 1, 3, 1, 1, 0, 8, 1, 0, 0);
    ex(0, mk("fwd_dm",      0, 1, 3, 2, 0, 0, 3, 1, 1, 1, 0));
    cyc(); drv(0, 1, 3, 2, 1, 1, 0, 9, 1, 0, 0);
    ex(0, mk("fwd_wb",      0, 3, 2, 0, 3, 0, 4, 1, 1, 1, 1));
    cyc(); bub(0);
    ex(0, mk("fwd_none",    0, 0, 0, 0, 0, 0, 7, 1, 1, 1, 1));

    // Load-use: LD R5 then ADD R6<-R5,R1
    cyc(); drv(0, 1, 1, 0, 1, 0, 0, 5, 1, 1, 0);
    ex(0, mk("ld_issue",    0, 1, 0, 0, 0, 0, 8, 0, 1, 1, 1));
    cyc(); drv(0, 1, 5, 1, 1, 1, 0, 6, 1, 0, 0);
    ex(0, mk("ld_op",       0, 5, 1, 0, 0, 0, 9, 1, 0, 1, 1));
    cyc(); bub(0);
    ex(0, mk("ld_stall",    1, 5, 1, X, X, 0, 0, 1, 1, 0, 1));
    cyc(); bub(0);
    ex(0, mk("ld_resume",   0, 0, 0, 2, 0, 0, 5, 1, 0, 1, 0));
    cyc(); bub(0);
    ex(0, mk("ld_drain",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));

    // Register 0 sink and immediate operand
    cyc(); drv(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    ex(0, mk("r0_issue",    0, 1, 0, X, X, 0, 6, 0, 0, 1, 0));
    cyc(); drv(0, 1, 0, 0, 1, 1, 0, 10, 1, 0, 0);
    ex(0, mk("r0_wr_op",    0, 0, 0, X, X, 0, 0, 1, 0, 0, 1));
    cyc(); drv(0, 1, 3, 0, 1, 0, 1, 11, 1, 0, 0);
    ex(0, mk("r0_read",     0, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    cyc(); bub(0);
    ex(0, mk("imm_op",      0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0));
    cyc(); bub(0);
    ex(0, mk("imm_clear",   0, 0, 0, 0, 0, 0, 10, 0, 1, 1, 1));

    // Flush in the load-use stall cycle
    cyc(); drv(0, 1, 2, 0, 1, 0, 0, 5, 1, 1, 0);
    ex(0, mk("fl_ld",       0, 2, 0, X, X, 0, 11, 0, 0, 1, 1));
    cyc(); drv(0, 1, 5, 5, 1, 1, 0, 12, 1, 0, 0);
    ex(0, mk("fl_use",      0, 5, 5, X, X, 0, 0, 1, 0, 0, 1));
    cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    ex(0, mk("fl_cycle",    0, 0, 0, X, X, 0, 0, 1, 1, 0, 0));
    cyc(); bub(0);
    ex(0, mk("fl_after",    0, 0, 0, 0, 0, 0, 5, 0, 0, 1, 0));

    // Non-forwarding instance: ADD R3<-R1,R2 then reader of R3
    cyc(); drv(1, 1, 1, 2, 1, 1, 0, 3, 1, 0, 0);
    ex(1, mk("nf_issue",    0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(); drv(1, 1, 3, 1, 1, 1, 0, 4, 1, 0, 0);
    ex(1, mk("nf_op",       0, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc(); bub(1);
    ex(1, mk("nf_stall1",   1, 3, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    cyc(); bub(1);
    ex(1, mk("nf_stall2",   1, 3, 1, 0, 0, 0, 3, 1, 0, 1, 0));
    cyc(); bub(1);
    ex(1, mk("nf_stall3",   1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 1));
    cyc(); bub(1);
    ex(1, mk("nf_release",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc(); bub(1);
    ex(1, mk("nf_ex",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    // Reset asserted in the middle of a stall
    cyc(); drv(1, 1, 1, 2, 1, 1, 0, 3, 1, 0, 0);
    ex(1, mk("nf_rs_issue", 0, 1, 2, 0, 0, 0, 4, 0, 0, 1, 0));
    cyc(); drv(1, 1, 3, 1, 1, 1, 0, 4, 1, 0, 0);
    ex(1, mk("nf_rs_op",    0, 3, 1, 0, 0, 0, 0, 1, 0, 0, 1));
    cyc(); bub(1);
    ex(1, mk("nf_rs_stall", 1, 3, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    cyc(); bub(1); rst = 1'b1;
    ex(1, mk("nf_rst_mid",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(); rst = 1'b0;
    ex(1, mk("nf_rst_rel",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    cyc();
    cyc();
    if (qf.size() != 0 || qn.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d/%0d required=0/0", qf.size(), qn.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
